branch_predictor_hybrid: RTL and testbench

//  Parametrised tournament predictor: gshare + per-PC bimodal table + per-PC chooser, all counter widths/depths configurable.

---
 rtl/branch_predictor_hybrid.sv | 123 ++++++++++++
 tb/tb_branch_predictor_hybrid.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_hybrid.sv
// Tournament branch predictor: gshare, per-PC bimodal and per-PC chooser tables,
// cleared by a post-reset sweep, with a speculative GHR repaired on mispredict.
module branch_predictor_hybrid #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_BITS   = 10,
  parameter int HIST_BITS  = 8,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_prediction,
  output logic                  o_req_pred_gshare,
  output logic                  o_req_pred_bimodal,
  output logic [HIST_BITS-1:0]  o_req_ghistory,
  output logic                  o_ready,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic [HIST_BITS-1:0]  i_fb_ghistory,
  input  logic                  i_fb_pred_gshare,
  input  logic                  i_fb_pred_bimodal,
  input  logic                  i_fb_prediction,
  input  logic                  i_fb_outcome
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WN  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                state_q;
  logic [IDX_BITS-1:0]   sweep_q;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;

  logic [CTR_BITS-1:0]   gshare_q  [DEPTH];
  logic [CTR_BITS-1:0]   bimodal_q [DEPTH];
  logic [CTR_BITS-1:0]   chooser_q [DEPTH];

  logic [IDX_BITS-1:0]   req_pc_idx, req_g_idx, fb_pc_idx, fb_g_idx;
  logic                  ready;
  logic                  gs_taken, bm_taken, use_gshare;

  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] ctr,
                                                   input logic up);
    if (up)
      return (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
    else
      return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  // Left shift works for HIST_BITS=1 too, where it degenerates to loading the new bit.
  function automatic logic [HIST_BITS-1:0] hist_shift(input logic [HIST_BITS-1:0] hist,
                                                      input logic bit_in);
    return (hist << 1) | HIST_BITS'(bit_in);
  endfunction

  assign ready      = (state_q == S_READY);
  assign req_pc_idx = i_req_pc[IDX_BITS+1:2];
  assign req_g_idx  = req_pc_idx ^ IDX_BITS'(ghr_q);
  assign fb_pc_idx  = i_fb_pc[IDX_BITS+1:2];
  assign fb_g_idx   = fb_pc_idx ^ IDX_BITS'(i_fb_ghistory);

  assign gs_taken   = gshare_q[req_g_idx][CTR_BITS-1];
  assign bm_taken   = bimodal_q[req_pc_idx][CTR_BITS-1];
  assign use_gshare = chooser_q[req_pc_idx][CTR_BITS-1];

  assign o_ready            = ready;
  assign o_req_pred_gshare  = ready & gs_taken;
  assign o_req_pred_bimodal = ready & bm_taken;
  assign o_req_prediction   = ready & (use_gshare ? gs_taken : bm_taken);
  assign o_req_ghistory     = ready ? ghr_q : '0;

  // Mispredict repair outranks the speculative shift of a same-cycle request.
  always_comb begin
    ghr_d = ghr_q;
    if (i_fb_valid && (i_fb_prediction != i_fb_outcome))
      ghr_d = hist_shift(i_fb_ghistory, i_fb_outcome);
    else if (i_req_valid)
      ghr_d = hist_shift(ghr_q, o_req_prediction);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (&sweep_q)
            state_q <= S_READY;
        end
        S_READY: ghr_q <= ghr_d;
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Table storage has no reset of its own; the sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        gshare_q[sweep_q]  <= CTR_WN;
        bimodal_q[sweep_q] <= CTR_WN;
        chooser_q[sweep_q] <= CTR_WN;
      end else if (i_fb_valid) begin
        gshare_q[fb_g_idx]   <= sat_step(gshare_q[fb_g_idx], i_fb_outcome);
        bimodal_q[fb_pc_idx] <= sat_step(bimodal_q[fb_pc_idx], i_fb_outcome);
        if (i_fb_pred_gshare != i_fb_pred_bimodal)
          chooser_q[fb_pc_idx] <= sat_step(chooser_q[fb_pc_idx],
                                           i_fb_pred_gshare == i_fb_outcome);
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:IDX_BITS+2], i_req_pc[1:0],
                            i_fb_pc[ADDR_WIDTH-1:IDX_BITS+2], i_fb_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_hybrid.sv
// Bench for branch_predictor_hybrid (IDX=4, HIST=4, CTR=2): directed scenarios plus
// randomized traffic compared every cycle against an integer-table reference model.
module tb_branch_predictor_hybrid;

  localparam int IDX   = 4;
  localparam int HIST  = 4;
  localparam int CTR   = 2;
  localparam int DEPTH = 1 << IDX;
  localparam int CMAX  = (1 << CTR) - 1;
  localparam int WN    = (1 << (CTR - 1)) - 1;
  localparam int HMASK = (1 << HIST) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic [31:0]     req_pc;
  logic            pred, pred_gs, pred_bm, ready;
  logic [HIST-1:0] req_ghist;
  logic            fb_valid;
  logic [31:0]     fb_pc;
  logic [HIST-1:0] fb_ghist;
  logic            fb_pred_gs, fb_pred_bm, fb_pred, fb_outcome;

  int checks   = 0;
  int failures = 0;

  int m_gs[DEPTH];
  int m_bm[DEPTH];
  int m_ch[DEPTH];
  int m_ghr;
  int m_init_left;

  branch_predictor_hybrid #(
    .ADDR_WIDTH(32), .IDX_BITS(IDX), .HIST_BITS(HIST), .CTR_BITS(CTR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_pc(req_pc),
    .o_req_prediction(pred), .o_req_pred_gshare(pred_gs), .o_req_pred_bimodal(pred_bm),
    .o_req_ghistory(req_ghist), .o_ready(ready),
    .i_fb_valid(fb_valid), .i_fb_pc(fb_pc), .i_fb_ghistory(fb_ghist),
    .i_fb_pred_gshare(fb_pred_gs), .i_fb_pred_bimodal(fb_pred_bm),
    .i_fb_prediction(fb_pred), .i_fb_outcome(fb_outcome)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int inc_sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic int dec_sat(input int v);
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output int pg, output int pb,
                                     output int pf);
    int pi;
    if (m_init_left != 0) begin
      pg = 0; pb = 0; pf = 0;
    end else begin
      pi = int'(pc >> 2) % DEPTH;
      pg = (m_gs[pi ^ m_ghr] > WN) ? 1 : 0;
      pb = (m_bm[pi] > WN) ? 1 : 0;
      pf = (m_ch[pi] > WN) ? pg : pb;
    end
  endfunction

  // Clearing the model tables at reset is observationally identical to the sweep,
  // since nothing can be read or trained until the sweep completes.
  function automatic void model_tick();
    int pg, pb, pf, fi, gi;
    if (!rst_n) begin
      m_init_left = DEPTH;
      m_ghr = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_gs[i] = WN; m_bm[i] = WN; m_ch[i] = WN;
      end
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      model_pred(req_pc, pg, pb, pf);
      if (fb_valid && (fb_pred != fb_outcome))
        m_ghr = ((int'(fb_ghist) << 1) | int'(fb_outcome)) & HMASK;
      else if (req_valid)
        m_ghr = ((m_ghr << 1) | pf) & HMASK;
      if (fb_valid) begin
        fi = int'(fb_pc >> 2) % DEPTH;
        gi = fi ^ int'(fb_ghist);
        m_gs[gi] = fb_outcome ? inc_sat(m_gs[gi]) : dec_sat(m_gs[gi]);
        m_bm[fi] = fb_outcome ? inc_sat(m_bm[fi]) : dec_sat(m_bm[fi]);
        if (fb_pred_gs != fb_pred_bm)
          m_ch[fi] = (fb_pred_gs == fb_outcome) ? inc_sat(m_ch[fi]) : dec_sat(m_ch[fi]);
      end
    end
  endfunction

  // Called at a negedge with inputs already driven; compares, clocks, advances the model.
  task automatic step();
    int pg, pb, pf;
    #1;
    model_pred(req_pc, pg, pb, pf);
    chk("ready",   32'(ready),     32'(m_init_left == 0));
    chk("pred",    32'(pred),      32'(pf));
    chk("pred_gs", 32'(pred_gs),   32'(pg));
    chk("pred_bm", 32'(pred_bm),   32'(pb));
    chk("ghist",   32'(req_ghist), (m_init_left == 0) ? 32'(m_ghr) : 32'd0);
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 0; req_pc = 0;
    fb_valid = 0; fb_pc = 0; fb_ghist = 0;
    fb_pred_gs = 0; fb_pred_bm = 0; fb_pred = 0; fb_outcome = 0;
  endtask

  task automatic feedback(input logic [31:0] pc, input logic [HIST-1:0] gh, input logic pgs,
                          input logic pbm, input logic pfin, input logic outc);
    fb_valid = 1; fb_pc = pc; fb_ghist = gh;
    fb_pred_gs = pgs; fb_pred_bm = pbm; fb_pred = pfin; fb_outcome = outc;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    @(posedge clk);
    model_tick();
    @(negedge clk);
    step();

    // Partial sweep interrupted at index 7, with feedback that must be discarded.
    rst_n = 1;
    fb_valid = 1; fb_outcome = 1; fb_pc = 32'h40;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("init_ready", 32'(ready), 32'd0);
      step();
    end
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      req_pc = 32'($urandom);
      #1;
      chk("sweep_ready", 32'(ready), 32'd0);
      chk("sweep_pred", 32'(pred | pred_gs | pred_bm), 32'd0);
      step();
    end
    idle();
    #1;
    chk("ready_17th", 32'(ready), 32'd1);

    // Bimodal entry 0 saturates at 3.
    feedback(32'h40, 4'h0, 0, 0, 1, 1);
    req_pc = 32'h40; #1;
    chk("bm_after_1", 32'(pred_bm), 32'd1);
    step();
    feedback(32'h40, 4'h0, 0, 0, 1, 1);
    feedback(32'h40, 4'h0, 0, 0, 1, 1);
    feedback(32'h40, 4'h0, 0, 0, 0, 0);
    req_pc = 32'h40; #1;
    chk("bm_sat_minus1", 32'(pred_bm), 32'd1);
    step();
    feedback(32'h40, 4'h0, 0, 0, 0, 0);
    req_pc = 32'h40; #1;
    chk("bm_sat_minus2", 32'(pred_bm), 32'd0);
    step();

    // Mispredict repair loads the GHR and wins over a same-cycle request shift.
    feedback(32'h8, 4'b0010, 0, 0, 0, 1);
    #1;
    chk("ghr_repair", 32'(req_ghist), 32'h5);
    req_valid = 1; req_pc = 32'h8;
    feedback(32'h8, 4'b0111, 0, 0, 0, 1);
    #1;
    chk("ghr_priority", 32'(req_ghist), 32'hF);
    step();

    // Chooser entry 1 driven to 3, so the final prediction follows gshare.
    feedback(32'h4, 4'h0, 1, 0, 1, 1);
    feedback(32'h4, 4'h0, 1, 0, 1, 1);
    req_pc = 32'h4; #1;
    chk("ch_bm", 32'(pred_bm), 32'd1);
    chk("ch_gs", 32'(pred_gs), 32'd0);
    chk("ch_final", 32'(pred), 32'd0);
    step();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      req_valid  = 1'($urandom);
      req_pc     = 32'($urandom);
      fb_valid   = 1'($urandom);
      fb_pc      = 32'($urandom);
      fb_ghist   = HIST'($urandom);
      fb_pred_gs = 1'($urandom);
      fb_pred_bm = 1'($urandom);
      fb_pred    = 1'($urandom);
      fb_outcome = 1'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
